sme_host_driver: RTL and testbench
==================================

Name: sme_host_driver

Overview:
- Host-side transmitter for the string-matching engine's serial byte interface.
- Accepts a string and a pattern from a host load port and buffers them.
- On start, streams the string, then the pattern, onto chardata/isstring/ispattern, then captures the engine's valid/match/match_index into a held result register.
- Sits between a host/testbench master and the matching engine top.

Parameters:
BYTE, 8, character width in bits
MAX_STRING, 32, string buffer depth in bytes
MAX_PATTERN, 8, pattern buffer depth in bytes
MAX_STR_ADD, 5, string index width (log2 MAX_STRING)
MAX_PAT_ADD, 3, pattern index width (log2 MAX_PATTERN)
TIMEOUT_CYC, 1023, maximum cycles spent in WAIT_RES before a timeout result is reported

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-low reset; asserted when reset==0
ld_valid  in  1  load byte strobe
ld_ready  out  1  load port ready; high only in IDLE
ld_sel  in  1  load target: 0 = string buffer, 1 = pattern buffer
ld_data  in  BYTE  load byte
start  in  1  single-cycle job start request
busy  out  1  high in any state other than IDLE
start_err  out  1  one-cycle pulse when start is rejected
ovf_err  out  1  sticky flag: a load byte was dropped because its buffer was full
chardata  out  BYTE  byte to the engine
isstring  out  1  chardata carries a string byte
ispattern  out  1  chardata carries a pattern byte
sme_valid  in  1  engine result strobe
sme_match  in  1  engine match flag
sme_index  in  MAX_STR_ADD  engine match index
res_valid  out  1  result available; held until accepted
res_ready  in  1  result consumer ready
res_match  out  1  captured match flag
res_index  out  MAX_STR_ADD  captured match index
res_timeout  out  1  result was produced by timeout, not by the engine

Behaviour:
- Reset state: state=IDLE; str_len=0 and pat_len=0; ovf_err=0. All outputs are 0 except ld_ready, which is 1.
  - Reset has the same effect mid-job: chardata/isstring/ispattern go to 0 on the next edge.
  - A pending result is discarded.
- States: IDLE, SEND_STR, SEND_PAT, WAIT_RES, DONE.
- IDLE, loading:
  - A load byte is accepted when ld_valid && ld_ready.
  - Accepted bytes write buf[len] of the selected buffer, then len increments.
  - If len equals the buffer depth, the byte is dropped, len is unchanged, and ovf_err is set.
  - ovf_err clears only at reset or when a DONE handshake completes.
- IDLE, start:
  - If str_len==0 or pat_len==0, no transition occurs and start_err pulses for 1 cycle.
  - Otherwise go to SEND_STR with idx=0.
  - If start and ld_valid occur together in IDLE, the load is performed and start is evaluated against the pre-load lengths.
- SEND_STR:
  - Each cycle drives chardata=str_buf[idx] and isstring=1, then increments idx.
  - At idx==str_len-1, go to SEND_PAT with idx=0.
  - The first string byte appears on the cycle after start is sampled.
  - Exactly str_len consecutive cycles with isstring=1.
- SEND_PAT:
  - Same as SEND_STR, using pat_buf, ispattern=1 and pat_len.
  - The first pattern byte directly follows the last string byte, with no gap.
  - isstring and ispattern are never both 1.
- WAIT_RES:
  - isstring=ispattern=0 and chardata=0.
  - A cycle counter starts at 0.
  - On sme_valid, capture sme_match and sme_index, set res_timeout=0, and go to DONE.
  - If the counter reaches TIMEOUT_CYC with no sme_valid, set res_match=0, res_index=0, res_timeout=1, and go to DONE.
  - sme_valid is ignored in every state except WAIT_RES.
- DONE:
  - res_valid=1 and the result fields are stable.
  - On res_ready, go to IDLE next cycle, clear res_valid, and reset str_len=pat_len=0, so buffers are single-use.
  - Further sme_valid pulses in DONE are ignored.
- start is ignored outside IDLE; start_err does not pulse in that case.
- ld_valid outside IDLE is not accepted because ld_ready=0.
- All driver outputs to the engine are registered.

Test Plan:
- Load string "ABCAB" (5 bytes) and pattern "CA" (2 bytes), then start -> 5 cycles isstring=1 with bytes 0x41 0x42 0x43 0x41 0x42, then 2 cycles ispattern=1 with 0x43 0x41, then both 0. Engine returns valid, match=1, index=2 -> res_valid=1, res_match=1, res_index=2, res_timeout=0.
- Start with pat_len=0 (string "AB" loaded) -> start_err pulses once, state stays IDLE, busy=0, no engine traffic.
- Load 33 string bytes -> str_len=32 and ovf_err=1; job streams exactly 32 string bytes.
- No sme_valid after the pattern -> after 1023 WAIT_RES cycles, res_valid=1, res_timeout=1, res_match=0, res_index=0.
- Hold res_ready=0 for 10 cycles in DONE -> result held stable; raise res_ready -> IDLE next cycle, ld_ready=1, lengths=0.
- Assert reset=0 during SEND_STR byte 3 -> next edge: isstring=0, busy=0, ld_ready=1, lengths=0; a following start is rejected with a start_err pulse.

Source files
------------

// File: rtl/sme_host_driver.sv
// Host-side byte streamer for the string-matching engine.
// Buffers a string and a pattern, streams them out, then holds the engine result.
module sme_host_driver #(
    parameter int BYTE        = 8,
    parameter int MAX_STRING  = 32,
    parameter int MAX_PATTERN = 8,
    parameter int MAX_STR_ADD = 5,
    parameter int MAX_PAT_ADD = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic                   ld_sel,
    input  logic [BYTE-1:0]        ld_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   start_err,
    output logic                   ovf_err,
    output logic [BYTE-1:0]        chardata,
    output logic                   isstring,
    output logic                   ispattern,
    input  logic                   sme_valid,
    input  logic                   sme_match,
    input  logic [MAX_STR_ADD-1:0] sme_index,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_match,
    output logic [MAX_STR_ADD-1:0] res_index,
    output logic                   res_timeout
);

    localparam int SLW = MAX_STR_ADD + 1;
    localparam int PLW = MAX_PAT_ADD + 1;
    localparam int CW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_STR,
        SEND_PAT,
        WAIT_RES,
        DONE
    } state_t;

    state_t state, state_d;

    logic [BYTE-1:0] str_buf [MAX_STRING];
    logic [BYTE-1:0] pat_buf [MAX_PATTERN];
    logic [SLW-1:0]  str_len;
    logic [PLW-1:0]  pat_len;

    logic [MAX_STR_ADD-1:0] idx, idx_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [BYTE-1:0]        chardata_d;
    logic                   isstring_d, ispattern_d;
    logic                   res_match_d, res_timeout_d;
    logic [MAX_STR_ADD-1:0] res_index_d;
    logic                   start_err_d;

    logic ld_fire, can_start, str_last, pat_last, done_fire;
    logic str_full, pat_full;

    assign ld_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    assign ld_fire   = ld_valid && ld_ready;
    assign done_fire = (state == DONE) && res_ready;
    assign can_start = (str_len != '0) && (pat_len != '0);
    assign str_full  = (str_len == SLW'(MAX_STRING));
    assign pat_full  = (pat_len == PLW'(MAX_PATTERN));
    assign str_last  = ({1'b0, idx} == str_len - SLW'(1));
    assign pat_last  = (idx == MAX_STR_ADD'(pat_len - PLW'(1)));

    // Engine-facing outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        cnt_d         = cnt;
        chardata_d    = '0;
        isstring_d    = 1'b0;
        ispattern_d   = 1'b0;
        res_match_d   = res_match;
        res_index_d   = res_index;
        res_timeout_d = res_timeout;
        start_err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (can_start) begin
                        state_d    = SEND_STR;
                        idx_d      = '0;
                        chardata_d = str_buf[0];
                        isstring_d = 1'b1;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            SEND_STR: begin
                if (str_last) begin
                    state_d     = SEND_PAT;
                    idx_d       = '0;
                    chardata_d  = pat_buf[0];
                    ispattern_d = 1'b1;
                end else begin
                    idx_d      = idx + MAX_STR_ADD'(1);
                    chardata_d = str_buf[idx_d];
                    isstring_d = 1'b1;
                end
            end
            SEND_PAT: begin
                if (pat_last) begin
                    state_d = WAIT_RES;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    idx_d       = idx + MAX_STR_ADD'(1);
                    chardata_d  = pat_buf[idx_d[MAX_PAT_ADD-1:0]];
                    ispattern_d = 1'b1;
                end
            end
            WAIT_RES: begin
                if (sme_valid) begin
                    state_d       = DONE;
                    res_match_d   = sme_match;
                    res_index_d   = sme_index;
                    res_timeout_d = 1'b0;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_d       = DONE;
                    res_match_d   = 1'b0;
                    res_index_d   = '0;
                    res_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            chardata    <= '0;
            isstring    <= 1'b0;
            ispattern   <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            chardata    <= chardata_d;
            isstring    <= isstring_d;
            ispattern   <= ispattern_d;
            res_match   <= res_match_d;
            res_index   <= res_index_d;
            res_timeout <= res_timeout_d;
            start_err   <= start_err_d;
        end
    end

    // Buffers are single-use: a completed result handshake empties them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            str_len <= '0;
            pat_len <= '0;
            ovf_err <= 1'b0;
        end else if (done_fire) begin
            str_len <= '0;
            pat_len <= '0;
            ovf_err <= 1'b0;
        end else if (ld_fire) begin
            if (!ld_sel) begin
                if (str_full) ovf_err <= 1'b1;
                else          str_len <= str_len + SLW'(1);
            end else begin
                if (pat_full) ovf_err <= 1'b1;
                else          pat_len <= pat_len + PLW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && ld_fire && !ld_sel && !str_full) begin
            str_buf[str_len[MAX_STR_ADD-1:0]] <= ld_data;
        end
        if (reset && ld_fire && ld_sel && !pat_full) begin
            pat_buf[pat_len[MAX_PAT_ADD-1:0]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_sme_host_driver.sv
// Directed plus randomized bench for sme_host_driver against a queue-based model.
module tb_sme_host_driver;

    localparam int MAXS = 32;
    localparam int MAXP = 8;
    localparam int TMO  = 1023;

    logic       clk = 1'b0;
    logic       reset, ld_valid, ld_sel, start;
    logic       sme_valid, sme_match, res_ready;
    logic [7:0] ld_data;
    logic [4:0] sme_index;
    logic       ld_ready, busy, start_err, ovf_err;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       res_valid, res_match, res_timeout;
    logic [4:0] res_index;

    int total = 0;
    int bad   = 0;

    byte unsigned q_str[$];
    byte unsigned q_pat[$];
    bit           m_ovf;

    sme_host_driver dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_data(ld_data),
        .start(start), .busy(busy),
        .start_err(start_err), .ovf_err(ovf_err),
        .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match),
        .sme_index(sme_index),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_match(res_match), .res_index(res_index),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(bit sel, logic [7:0] d);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_data  = d;
        step();
        ld_valid = 1'b0;
        if (!sel) begin
            if (q_str.size() < MAXS) q_str.push_back(d);
            else m_ovf = 1'b1;
        end else begin
            if (q_pat.size() < MAXP) q_pat.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic start_reject(string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_err"}, start_err, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_str"}, isstring, 0);
        step();
        check({tag, "_pulse"}, start_err, 0);
        check({tag, "_idle"}, ld_ready, 1);
    endtask

    task automatic run_job(bit respond, int delay, bit mt,
                           logic [4:0] ix, int hold);
        byte unsigned stream[$];
        bit           kind[$];
        logic         e_m, e_t;
        logic [4:0]   e_i;
        foreach (q_str[i]) begin
            stream.push_back(q_str[i]);
            kind.push_back(1'b0);
        end
        foreach (q_pat[i]) begin
            stream.push_back(q_pat[i]);
            kind.push_back(1'b1);
        end
        start = 1'b1;
        step();
        foreach (stream[i]) begin
            check("s_isstr", isstring, !kind[i]);
            check("s_ispat", ispattern, kind[i]);
            check("s_data", chardata, stream[i]);
            check("s_serr", start_err, 0);
            start     = 1'($urandom);
            ld_valid  = 1'($urandom);
            ld_sel    = 1'($urandom);
            ld_data   = 8'($urandom);
            sme_valid = 1'($urandom);
            step();
        end
        start     = 1'b0;
        ld_valid  = 1'b0;
        sme_valid = 1'b0;
        check("w_isstr", isstring, 0);
        check("w_ispat", ispattern, 0);
        check("w_data", chardata, 0);
        check("w_busy", busy, 1);
        check("w_rv", res_valid, 0);
        if (respond) begin
            repeat (delay) step();
            check("w_rv2", res_valid, 0);
            sme_valid = 1'b1;
            sme_match = mt;
            sme_index = ix;
            step();
            sme_valid = 1'b0;
            e_m = mt;
            e_i = ix;
            e_t = 1'b0;
        end else begin
            repeat (TMO - 1) step();
            check("pre_tmo_rv", res_valid, 0);
            step();
            e_m = 1'b0;
            e_i = '0;
            e_t = 1'b1;
        end
        check("r_valid", res_valid, 1);
        check("r_match", res_match, e_m);
        check("r_index", res_index, e_i);
        check("r_tmo", res_timeout, e_t);
        check("r_ldrdy", ld_ready, 0);
        res_ready = 1'b0;
        repeat (hold) begin
            sme_valid = 1'($urandom);
            sme_match = 1'($urandom);
            sme_index = 5'($urandom);
            step();
            check("h_valid", res_valid, 1);
            check("h_fields", {res_match, res_index, res_timeout},
                  {e_m, e_i, e_t});
        end
        sme_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        q_str.delete();
        q_pat.delete();
        m_ovf = 1'b0;
        check("a_rv", res_valid, 0);
        check("a_ldrdy", ld_ready, 1);
        check("a_busy", busy, 0);
        check("a_ovf", ovf_err, m_ovf);
        start_reject("a_empty");
    endtask

    initial begin
        byte unsigned abcab[5];
        int           ns, np;
        abcab = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42};
        reset = 1'b0;
        ld_valid = 1'b0; ld_sel = 1'b0; ld_data = '0;
        start = 1'b0; sme_valid = 1'b0; sme_match = 1'b0;
        sme_index = '0; res_ready = 1'b0;
        m_ovf = 1'b0;
        step();
        step();
        check("rst_ldrdy", ld_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_serr", start_err, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_out", {chardata, isstring, ispattern}, 0);
        check("rst_res", {res_valid, res_match, res_index, res_timeout}, 0);
        reset = 1'b1;
        step();

        foreach (abcab[i]) load(1'b0, abcab[i]);
        load(1'b1, 8'h43);
        load(1'b1, 8'h41);
        check("abc_ovf", ovf_err, 0);
        run_job(1'b1, 3, 1'b1, 5'd2, 2);

        load(1'b0, 8'h41);
        load(1'b0, 8'h42);
        start_reject("nopat");

        start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b1; ld_data = 8'h43;
        step();
        start = 1'b0; ld_valid = 1'b0;
        q_pat.push_back(8'h43);
        check("sim_err", start_err, 1);
        check("sim_busy", busy, 0);
        step();
        run_job(1'b1, 0, 1'b0, 5'd0, 1);

        for (int i = 0; i < 33; i++) load(1'b0, 8'($urandom));
        load(1'b1, 8'h5a);
        check("ovf_set", ovf_err, m_ovf);
        check("ovf_len", q_str.size(), 32);
        run_job(1'b0, 0, 1'b0, 5'd0, 10);

        load(1'b0, 8'h11);
        for (int i = 0; i < 9; i++) load(1'b1, 8'($urandom));
        check("povf_set", ovf_err, 1);
        run_job(1'b1, 5, 1'b1, 5'd31, 3);

        for (int i = 0; i < 6; i++) load(1'b0, 8'($urandom));
        load(1'b1, 8'h01);
        load(1'b1, 8'h02);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mr_data", chardata, q_str[i]);
            step();
        end
        check("mr_b3", {isstring, chardata}, {1'b1, q_str[3]});
        reset = 1'b0;
        step();
        reset = 1'b1;
        q_str.delete();
        q_pat.delete();
        m_ovf = 1'b0;
        check("mr_isstr", isstring, 0);
        check("mr_data0", chardata, 0);
        check("mr_busy", busy, 0);
        check("mr_ldrdy", ld_ready, 1);
        start_reject("mr_empty");

        for (int j = 0; j < 10; j++) begin
            ns = int'($urandom_range(1, MAXS + 2));
            np = int'($urandom_range(1, MAXP + 1));
            for (int i = 0; i < ns; i++) load(1'b0, 8'($urandom));
            for (int i = 0; i < np; i++) load(1'b1, 8'($urandom));
            check("rnd_ovf", ovf_err, m_ovf);
            run_job(j != 4, int'($urandom_range(0, 30)), 1'($urandom),
                    5'($urandom), int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
